mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: max consecutive data grants while iREN is pending before instruction is forced.
REQ-002 CLK  in  1  system clock, rising edge.
REQ-003 nRST  in  1  asynchronous, active-low reset; one clock domain only.
REQ-004 iREN  in  1  instruction read request.
REQ-005 iaddr  in  32  instruction address (word_t).
REQ-006 iwait  out  1  instruction stall; 0 for exactly the ACCESS cycle of a granted fetch.
REQ-007 iload  out  32  instruction data.
REQ-008 dREN / dWEN  in  1 each  data read / write request.
REQ-009 daddr, dstore  in  32 each  data address / store data.
REQ-010 dwait  out  1  data stall; 0 for exactly the ACCESS cycle of a granted data op.
REQ-011 dload  out  32  data load value.
REQ-012 ramREN, ramWEN  out  1 each  RAM read / write strobe.
REQ-013 ramaddr, ramstore  out  32 each  RAM address / write data.
REQ-014 ramload  in  32  RAM read data.
REQ-015 ramstate  in  2  ramstate_t: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
REQ-016 ramerr  out  1  sticky flag: an ERROR response has been seen.

Function
REQ-017 FSM states: IDLE, IGNT, DRD, DWR; state register updates only on CLK rising edge.
REQ-018 Arbitration, in IDLE or in the ACCESS cycle of a grant: dWEN->DWR, else dREN->DRD, else iREN->IGNT, else IDLE; exception: iREN=1 and starve count == STARVE_MAX -> IGNT.
REQ-019 Back-to-back grants: the ACCESS cycle moves directly to the next arbitrated state, with no IDLE bubble.
REQ-020 dREN=dWEN=1 together is treated as a write.
REQ-021 IGNT drives ramREN=1, ramaddr=iaddr; DRD drives ramREN=1, ramaddr=daddr; DWR drives ramWEN=1, ramaddr=daddr, ramstore=dstore; IDLE drives all four to 0.
REQ-022 ramREN and ramWEN are never 1 in the same cycle.
REQ-023 iwait = ~(state==IGNT && ramstate==ACCESS); dwait = ~((DRD||DWR) && ramstate==ACCESS); both combinational.
REQ-024 iload = ramload when iwait=0, else 0; dload = ramload when DRD and dwait=0, else 0.
REQ-025 ramstate FREE/BUSY: hold state and outputs, with waits asserted; there is no timeout.
REQ-026 ramstate ERROR: set ramerr; hold state so the access is retried; waits stay asserted.
REQ-027 Abort: if the granted requester's request drops before ACCESS, the next state is arbitrated as from IDLE, with no completion signalled.
REQ-028 Starve counter, 0..STARVE_MAX, saturating: increments on a data ACCESS cycle while iREN=1; clears on an instruction ACCESS cycle or any cycle with iREN=0.
REQ-029 Latency: a request into idle FREE RAM is granted on the next edge; completion is the first ACCESS cycle after that.

Reset
REQ-030 While nRST=0, the following hold: state=IDLE, starve counter=0, ramerr=0.
REQ-031 While nRST=0, the outputs are: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iwait=1, dwait=1, iload=0, dload=0.
REQ-032 Reset asserted mid-grant abandons the access immediately, with no completion pulse.
REQ-033 After reset release, arbitration resumes on the first rising edge.

Structure
REQ-034 ramstate_t, word_t and a new arb_state_t enum belong in cpu_types_pkg.
REQ-035 STARVE_MAX stays a module parameter.
REQ-036 The block is a single module with no sub-modules; the starve counter and FSM are inline.

Verification
REQ-037 Scenario: iREN=1, iaddr=0x0000_0040, RAM gives 2 BUSY then ACCESS with ramload=0x2408_0005 -> ramREN=1, ramaddr=0x40 for 3 cycles; iwait=0 and iload=0x2408_0005 only in cycle 3.
REQ-038 Scenario: iREN=1 and dREN=1 (daddr=0x100) held, RAM ACCESS every cycle, STARVE_MAX=4 -> grants are D,D,D,D,I,D,D,D,D,I.
REQ-039 Scenario: dREN=1 and dWEN=1, daddr=0x200, dstore=0xDEAD_BEEF -> ramWEN=1, ramREN=0, ramstore=0xDEAD_BEEF; dload=0 on completion.
REQ-040 Scenario: data read gets ERROR for 1 cycle, then ACCESS -> ramerr=1 and stays 1; dwait=0 in cycle 2 only.
REQ-041 Scenario: dREN=1 granted, dREN drops during BUSY while iREN=1 -> next cycle IGNT with ramaddr=iaddr; no dwait=0 pulse.
REQ-042 Scenario: nRST pulled low during a DWR BUSY cycle -> ramWEN=0 immediately; after release, state=IDLE and starve count=0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared CPU memory-side types: word, RAM handshake state and arbiter FSM state.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DRD  = 2'd2,
        DWR  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Instruction/data request ports and the single shared RAM port of the arbiter.
interface mem_arbiter_if;
    import cpu_types_pkg::*;

    logic      iREN;
    word_t     iaddr;
    logic      iwait;
    word_t     iload;

    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dwait;
    word_t     dload;

    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;
    logic      ramerr;

    // arbiter side
    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, ramerr
    );

    // CPU + RAM side
    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, ramerr
    );

endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch vs data read/write onto one RAM port; grant lands one edge after request,
// completion is the RAM ACCESS cycle; FREE/BUSY/ERROR stall the requester indefinitely.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic         CLK,
    input  logic         nRST,
    mem_arbiter_if.slave bus
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_TOP = CW'(STARVE_MAX);

    arb_state_t    state_q, state_d;
    logic [CW-1:0] starve_q, starve_d;
    logic          ramerr_q, ramerr_d;

    logic access;
    logic i_done;
    logic d_done;
    logic req_held;

    always_comb begin
        access = (bus.ramstate == ACCESS);
        i_done = (state_q == IGNT) && access;
        d_done = ((state_q == DRD) || (state_q == DWR)) && access;
        case (state_q)
            IGNT:    req_held = bus.iREN;
            DRD:     req_held = bus.dREN;
            DWR:     req_held = bus.dWEN;
            default: req_held = 1'b0;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (!bus.iREN || i_done) begin
            starve_d = '0;
        end else if (d_done && (starve_q != STARVE_TOP)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // Re-arbitrate from IDLE (req_held is 0), on completion, or when the owner abandons its request.
    // The post-update starve count is used so the forced fetch follows exactly STARVE_MAX data grants.
    always_comb begin
        state_d = state_q;
        if (access || !req_held) begin
            if (bus.iREN && (starve_d == STARVE_TOP)) begin
                state_d = IGNT;
            end else if (bus.dWEN) begin
                state_d = DWR;
            end else if (bus.dREN) begin
                state_d = DRD;
            end else if (bus.iREN) begin
                state_d = IGNT;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_comb begin
        ramerr_d = ramerr_q | ((state_q != IDLE) && (bus.ramstate == ERROR));
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            starve_q <= '0;
            ramerr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            ramerr_q <= ramerr_d;
        end
    end

    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        case (state_q)
            IGNT: begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = bus.iaddr;
            end
            DRD: begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = bus.daddr;
            end
            DWR: begin
                bus.ramWEN   = 1'b1;
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
            end
            default: ;
        endcase
        bus.iwait  = ~i_done;
        bus.dwait  = ~d_done;
        bus.iload  = i_done ? bus.ramload : '0;
        bus.dload  = ((state_q == DRD) && access) ? bus.ramload : '0;
        bus.ramerr = ramerr_q;
    end

    strobe_exclusive: assert property (@(posedge CLK) disable iff (!nRST) !(bus.ramREN && bus.ramWEN));

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against an ownership-level model.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int SM     = 4;
    localparam int O_NONE = 0;
    localparam int O_I    = 1;
    localparam int O_DR   = 2;
    localparam int O_DW   = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if bus();

    mem_arbiter #(.STARVE_MAX(SM)) dut (
        .CLK  (clk),
        .nRST (rst_n),
        .bus  (bus)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [65:0] exp_q[$];
    string       done_log = "";

    int   m_owner  = O_NONE;
    int   m_streak = 0;
    logic m_err    = 1'b0;

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic check_str(string name, string act, string exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got '%s' expected '%s'", name, $time, act, exp);
        end
    endtask

    // Who wins the port given the current requests and how many data grants instruction has waited through.
    function automatic int pick(logic ir, logic dr, logic dw, int streak);
        if (ir && streak >= SM) return O_I;
        if (dw) return O_DW;
        if (dr) return O_DR;
        if (ir) return O_I;
        return O_NONE;
    endfunction

    always @(negedge clk) begin : model
        logic  done;
        logic  still;
        word_t ea;
        word_t es;
        if (!rst_n) begin
            m_owner  = O_NONE;
            m_streak = 0;
            m_err    = 1'b0;
            check("reset_bus", {bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore, bus.ramerr}, '0);
        end else begin
            ea = (m_owner == O_I) ? bus.iaddr : ((m_owner == O_NONE) ? 32'h0 : bus.daddr);
            es = (m_owner == O_DW) ? bus.dstore : 32'h0;
            check("ram_bus", {bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore, bus.ramerr},
                  {(m_owner == O_I) || (m_owner == O_DR), m_owner == O_DW, ea, es, m_err});
            done = (m_owner != O_NONE) && (bus.ramstate == ACCESS);
            if (done) begin
                case (m_owner)
                    O_I:     exp_q.push_back({1'b0, 1'b1, bus.ramload, 32'h0});
                    O_DR:    exp_q.push_back({1'b1, 1'b0, 32'h0, bus.ramload});
                    default: exp_q.push_back({1'b1, 1'b0, 32'h0, 32'h0});
                endcase
            end
            if ((m_owner != O_NONE) && (bus.ramstate == ERROR)) m_err = 1'b1;
            if (!bus.iREN) m_streak = 0;
            else if (done && m_owner == O_I) m_streak = 0;
            else if (done) m_streak = (m_streak < SM) ? m_streak + 1 : SM;
            still = (m_owner == O_I && bus.iREN) || (m_owner == O_DR && bus.dREN) ||
                    (m_owner == O_DW && bus.dWEN);
            if (done || !still) m_owner = pick(bus.iREN, bus.dREN, bus.dWEN, m_streak);
        end
    end

    always @(negedge clk) begin : monitor
        logic [65:0] exp_v;
        #1;
        exp_v = {2'b11, 64'h0};
        if (exp_q.size() > 0) exp_v = exp_q.pop_front();
        check("completion", {bus.iwait, bus.dwait, bus.iload, bus.dload}, exp_v);
        if (!bus.iwait) done_log = {done_log, "I"};
        else if (!bus.dwait) done_log = {done_log, "D"};
    end

    task automatic drive(logic ir, word_t ia, logic dr, logic dw, word_t da, word_t ds,
                         ramstate_t rs, word_t rl);
        bus.iREN     = ir;
        bus.iaddr    = ia;
        bus.dREN     = dr;
        bus.dWEN     = dw;
        bus.daddr    = da;
        bus.dstore   = ds;
        bus.ramstate = rs;
        bus.ramload  = rl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
    endtask

    initial begin : stim
        logic      ir;
        logic      dr;
        logic      dw;
        int        r;
        ramstate_t rs;

        rst_n = 1'b0;
        repeat (3) idle();
        rst_n = 1'b1;
        idle();

        // fetch with two BUSY cycles before ACCESS
        done_log = "";
        drive(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
        drive(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, BUSY, 32'h0);
        drive(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, BUSY, 32'h0);
        drive(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, ACCESS, 32'h2408_0005);
        idle();
        check_str("fetch_log", done_log, "I");

        // read+write together is a write; no load data on completion
        done_log = "";
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, FREE, 32'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, BUSY, 32'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, ACCESS, 32'h1234_5678);
        idle();
        check_str("write_log", done_log, "D");

        // one ERROR cycle then ACCESS; error flag is sticky
        done_log = "";
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0, FREE, 32'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0, ERROR, 32'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0, ACCESS, 32'hCAFE_0001);
        idle();
        idle();
        check("ramerr_sticky", bus.ramerr, 1'b1);
        check_str("err_log", done_log, "D");

        // data read abandoned during BUSY hands the port to the pending fetch
        done_log = "";
        drive(1'b1, 32'h80, 1'b1, 1'b0, 32'h100, 32'h0, FREE, 32'h0);
        drive(1'b1, 32'h80, 1'b1, 1'b0, 32'h100, 32'h0, BUSY, 32'h0);
        drive(1'b1, 32'h80, 1'b0, 1'b0, 32'h100, 32'h0, BUSY, 32'h0);
        check("abort_ramaddr", {bus.ramREN, bus.ramaddr}, {1'b1, 32'h80});
        drive(1'b1, 32'h80, 1'b0, 1'b0, 32'h100, 32'h0, ACCESS, 32'h0BAD_0080);
        idle();
        check_str("abort_log", done_log, "I");

        // starvation bound with both requesters held and RAM always ready
        idle();
        done_log = "";
        for (int i = 0; i < 11; i++)
            drive(1'b1, 32'h40, 1'b1, 1'b0, 32'h100, 32'h0, ACCESS, 32'h1111_0000 + 32'(i));
        idle();
        check_str("starve_seq", done_log, "DDDDIDDDDI");

        // reset in the middle of a write's BUSY cycle
        drive(1'b1, 32'h44, 1'b0, 1'b1, 32'h400, 32'h55AA_55AA, FREE, 32'h0);
        drive(1'b1, 32'h44, 1'b0, 1'b1, 32'h400, 32'h55AA_55AA, BUSY, 32'h0);
        check("wen_before_rst", bus.ramWEN, 1'b1);
        #1 rst_n = 1'b0;
        #1 check("wen_in_rst", {bus.ramWEN, bus.ramaddr, bus.ramstore, bus.dwait}, {1'b0, 64'h0, 1'b1});
        drive(1'b1, 32'h44, 1'b0, 1'b1, 32'h400, 32'h55AA_55AA, BUSY, 32'h0);
        drive(1'b1, 32'h44, 1'b0, 1'b1, 32'h400, 32'h55AA_55AA, ACCESS, 32'h0);
        rst_n = 1'b1;
        check("ramerr_after_rst", bus.ramerr, 1'b0);
        // starvation count restarts from zero after reset
        done_log = "";
        for (int i = 0; i < 6; i++)
            drive(1'b1, 32'h48, 1'b1, 1'b0, 32'h104, 32'h0, ACCESS, 32'h2222_0000 + 32'(i));
        idle();
        check_str("post_rst_seq", done_log, "DDDDI");

        // random traffic
        ir = 1'b0;
        dr = 1'b0;
        dw = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 7) == 0) ir = ~ir;
            if ($urandom_range(0, 3) == 0) dr = ~dr;
            if ($urandom_range(0, 5) == 0) dw = ~dw;
            r = int'($urandom_range(0, 19));
            if (r < 10) rs = ACCESS;
            else if (r < 15) rs = BUSY;
            else if (r < 18) rs = FREE;
            else rs = ERROR;
            drive(ir, $urandom, dr, dw, $urandom, $urandom, rs, $urandom);
        end

        idle();
        idle();
        check("queue_drained", 128'(exp_q.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no end expected $finish");
        $fatal(1, "time limit");
    end

endmodule
